// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master: it raises a request with a word address and
// the memory answers with ack plus read data in the cycle the fetch completes.
interface fetch_ifid_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the RV32 core.
// Holds the PC, fetches over the req/ack imem bus, and delivers instruction,
// PC and PC+4 to decode. Hazard-unit stall/flush and execute redirects are
// honoured with priority rst > redirect > flush > stall > normal. A one-entry
// hold buffer keeps a word that completes while decode is stalled.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/wait performance counters.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    input  logic                stall_d_i,
    input  logic                flush_d_i,
    fetch_ifid_stage_if.master  imem,
    output logic [31:0]         instr_d_o,
    output logic [31:0]         pc_d_o,
    output logic [31:0]         pc_plus4_d_o,
    output logic                valid_d_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt_o,
    output logic [31:0]         wait_cnt_o
`endif
);

    // REQ: request outstanding at pc_f. HOLD: a fetched word waits in the buffer.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;

    // One-entry hold buffer; only meaningful while in S_HOLD.
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic        buf_load;

    // IF/ID pipeline register.
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic        req;
    logic        transfer;
    logic [31:0] pc_f_plus4;

    // The request is suppressed in the reset cycle so a reset mid-wait cannot
    // complete a stale fetch.
    assign req        = (state_q == S_REQ) && !rst;
    assign transfer   = req && imem.imem_ack_i;
    assign pc_f_plus4 = pc_f_q + 32'd4;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_f_q;

    assign instr_d_o    = id_instr_q;
    assign pc_d_o       = id_pc_q;
    assign pc_plus4_d_o = id_pc4_q;
    assign valid_d_o    = id_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next-PC, hold-buffer and IF/ID selection in priority order.
    always_comb begin
        // NOTE: every variable is defaulted first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        buf_load    = 1'b0;
        buf_instr_d = imem.imem_rdata_i;
        buf_pc_d    = pc_f_q;
        buf_pc4_d   = pc_f_plus4;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        id_valid_d  = id_valid_q;

        if (redirect_i) begin
            // Abandon the outstanding request and any buffered word.
            state_d    = S_REQ;
            pc_f_d     = redirect_pc_i & ~32'h0000_0003;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (flush_d_i) begin
            // Bubble IF/ID; a same-cycle completion is consumed and dropped.
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            if (state_q == S_HOLD) begin
                state_d = S_REQ;
            end else if (transfer) begin
                pc_f_d = pc_f_plus4;
            end
        end else if (stall_d_i) begin
            // IF/ID holds; a completing fetch parks in the hold buffer.
            if ((state_q == S_REQ) && transfer) begin
                buf_load = 1'b1;
                pc_f_d   = pc_f_plus4;
                state_d  = S_HOLD;
            end
        end else begin
            if (state_q == S_HOLD) begin
                id_instr_d = buf_instr_q;
                id_pc_d    = buf_pc_q;
                id_pc4_d   = buf_pc4_q;
                id_valid_d = 1'b1;
                state_d    = S_REQ;
            end else if (transfer) begin
                id_instr_d = imem.imem_rdata_i;
                id_pc_d    = pc_f_q;
                id_pc4_d   = pc_f_plus4;
                id_valid_d = 1'b1;
                pc_f_d     = pc_f_plus4;
            end else begin
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
        end
    end

    // PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q     <= RESET_PC;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 32'h0000_0000;
            id_pc4_q   <= 32'h0000_0000;
            id_valid_q <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Hold-buffer payload capture.
    always_ff @(posedge clk) begin
        // NOTE: the payload is not reset; emptiness is tracked by state_q, so
        // the data is never observed before it has been written.
        if (buf_load) begin
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_pc4_q   <= buf_pc4_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] wait_cnt_q;

    // Count accepted transfers and request cycles spent waiting for ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0000_0000;
            wait_cnt_q  <= 32'h0000_0000;
        end else begin
            if (transfer && !redirect_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (req && !imem.imem_ack_i) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed self-checking bench for fetch_ifid_stage. Inputs change and outputs
// are sampled around the falling edge; the DUT updates on the rising edge.
module tb_fetch_ifid_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_d_i;
    logic        flush_d_i;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] wait_cnt_o;
`endif

    int asserts;
    int failures;

    fetch_ifid_stage_if imem ();

    fetch_ifid_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_d_i    (stall_d_i),
        .flush_d_i    (flush_d_i),
        .imem         (imem),
        .instr_d_o    (instr_d_o),
        .pc_d_o       (pc_d_o),
        .pc_plus4_d_o (pc_plus4_d_o),
        .valid_d_o    (valid_d_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .wait_cnt_o   (wait_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset across one rising edge; returns at a falling edge in cycle 1.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; redirect_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        redirect_pc_i = 32'h0; imem.imem_ack_i = 1'b0; imem.imem_rdata_i = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Drive an ack for the current address with the reference data pattern.
    task automatic ack_now(input logic [31:0] addr);
        imem.imem_ack_i   = 1'b1;
        imem.imem_rdata_i = addr ^ KEY;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; imem.imem_ack_i = 1'b0;
        redirect_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0; redirect_pc_i = 32'h0;
        #1;
        asserts++; if (imem.imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b exp 0", imem.imem_req_o); end
        @(negedge clk);
        asserts++; if (valid_d_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", valid_d_o); end
        asserts++; if (instr_d_o !== NOP) begin failures++; $display("FAIL rst_instr: got %h exp %h", instr_d_o, NOP); end
        asserts++; if (pc_d_o !== 32'h0 || pc_plus4_d_o !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h/%h exp 0/0", pc_d_o, pc_plus4_d_o); end
        rst = 1'b0;
        #1;
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_first_req: got %b@%h exp 1@0", imem.imem_req_o, imem.imem_addr_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        reset_dut();
        for (int i = 0; i <= 6; i++) begin
            exp = 32'(4 * i);
            if (i < 6) begin
                asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== exp) begin failures++; $display("FAIL stream_addr[%0d]: got %b@%h exp 1@%h", i, imem.imem_req_o, imem.imem_addr_o, exp); end
            end
            if (i > 0) begin
                asserts++; if (valid_d_o !== 1'b1 || pc_d_o !== exp - 32'd4) begin failures++; $display("FAIL stream_pc[%0d]: got %b/%h exp 1/%h", i, valid_d_o, pc_d_o, exp - 32'd4); end
                asserts++; if (instr_d_o !== ((exp - 32'd4) ^ KEY) || pc_plus4_d_o !== exp) begin failures++; $display("FAIL stream_data[%0d]: got %h/%h exp %h/%h", i, instr_d_o, pc_plus4_d_o, (exp - 32'd4) ^ KEY, exp); end
            end
            if (i < 6) ack_now(exp); else imem.imem_ack_i = 1'b0;
            @(negedge clk);
        end
        asserts++; if (valid_d_o !== 1'b0 || instr_d_o !== NOP) begin failures++; $display("FAIL stream_idle_bubble: got %b/%h exp 0/%h", valid_d_o, instr_d_o, NOP); end
`ifdef FETCH_PERF_CNT_EN
        asserts++; if (fetch_cnt_o !== 32'd6) begin failures++; $display("FAIL stream_fetch_cnt: got %0d exp 6", fetch_cnt_o); end
`endif
    endtask

    task automatic test_wait();
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 4; w++) begin
                asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'(4 * k)) begin failures++; $display("FAIL wait_addr[%0d.%0d]: got %b@%h exp 1@%h", k, w, imem.imem_req_o, imem.imem_addr_o, 4 * k); end
                if (w > 0) begin
                    asserts++; if (valid_d_o !== 1'b0 || instr_d_o !== NOP) begin failures++; $display("FAIL wait_bubble[%0d.%0d]: got %b/%h exp 0/%h", k, w, valid_d_o, instr_d_o, NOP); end
                end
                if (w == 3) ack_now(32'(4 * k)); else imem.imem_ack_i = 1'b0;
                @(negedge clk);
            end
            asserts++; if (valid_d_o !== 1'b1 || pc_d_o !== 32'(4 * k)) begin failures++; $display("FAIL wait_deliver[%0d]: got %b/%h exp 1/%h", k, valid_d_o, pc_d_o, 4 * k); end
        end
        imem.imem_ack_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        asserts++; if (wait_cnt_o !== 32'd6 || fetch_cnt_o !== 32'd2) begin failures++; $display("FAIL wait_counters: got %0d/%0d exp 6/2", wait_cnt_o, fetch_cnt_o); end
`endif
    endtask

    task automatic test_stall();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            ack_now(32'(4 * i));
            @(negedge clk);
        end
        asserts++; if (imem.imem_addr_o !== 32'h10 || pc_d_o !== 32'h0C) begin failures++; $display("FAIL stall_setup: got %h/%h exp 10/0c", imem.imem_addr_o, pc_d_o); end
        ack_now(32'h10); stall_d_i = 1'b1;
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (imem.imem_req_o !== 1'b0 || pc_d_o !== 32'h0C || valid_d_o !== 1'b1) begin failures++; $display("FAIL stall_hold1: got req %b pc %h v %b exp 0/0c/1", imem.imem_req_o, pc_d_o, valid_d_o); end
        @(negedge clk);
        asserts++; if (imem.imem_req_o !== 1'b0 || pc_d_o !== 32'h0C || instr_d_o !== (32'h0C ^ KEY)) begin failures++; $display("FAIL stall_hold2: got req %b pc %h i %h exp 0/0c/%h", imem.imem_req_o, pc_d_o, instr_d_o, 32'h0C ^ KEY); end
        stall_d_i = 1'b0;
        @(negedge clk);
        asserts++; if (pc_d_o !== 32'h10 || instr_d_o !== (32'h10 ^ KEY) || valid_d_o !== 1'b1 || pc_plus4_d_o !== 32'h14) begin failures++; $display("FAIL stall_release: got %h/%h/%b exp 10/%h/1", pc_d_o, instr_d_o, valid_d_o, 32'h10 ^ KEY); end
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h14) begin failures++; $display("FAIL stall_next_req: got %b@%h exp 1@14", imem.imem_req_o, imem.imem_addr_o); end
        ack_now(32'h14);
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (pc_d_o !== 32'h14 || valid_d_o !== 1'b1) begin failures++; $display("FAIL stall_after: got %h/%b exp 14/1", pc_d_o, valid_d_o); end
    endtask

    task automatic test_redirect();
        reset_dut();
        ack_now(32'h0); @(negedge clk);
        ack_now(32'h4); @(negedge clk);
        ack_now(32'h8); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
        @(negedge clk);
        redirect_i = 1'b0;
        asserts++; if (valid_d_o !== 1'b0 || instr_d_o !== NOP) begin failures++; $display("FAIL redir_bubble: got %b/%h exp 0/%h", valid_d_o, instr_d_o, NOP); end
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h200) begin failures++; $display("FAIL redir_addr: got %b@%h exp 1@200", imem.imem_req_o, imem.imem_addr_o); end
        ack_now(32'h200);
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (pc_d_o !== 32'h200 || valid_d_o !== 1'b1 || instr_d_o !== (32'h200 ^ KEY)) begin failures++; $display("FAIL redir_deliver: got %h/%b/%h exp 200/1/%h", pc_d_o, valid_d_o, instr_d_o, 32'h200 ^ KEY); end
    endtask

    task automatic test_flush_hold();
        reset_dut();
        ack_now(32'h0); @(negedge clk);
        ack_now(32'h4); stall_d_i = 1'b1;
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (imem.imem_req_o !== 1'b0 || pc_d_o !== 32'h0) begin failures++; $display("FAIL flush_setup: got req %b pc %h exp 0/0", imem.imem_req_o, pc_d_o); end
        stall_d_i = 1'b0; flush_d_i = 1'b1;
        @(negedge clk);
        flush_d_i = 1'b0;
        asserts++; if (valid_d_o !== 1'b0 || instr_d_o !== NOP) begin failures++; $display("FAIL flush_bubble: got %b/%h exp 0/%h", valid_d_o, instr_d_o, NOP); end
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h8) begin failures++; $display("FAIL flush_resume: got %b@%h exp 1@8", imem.imem_req_o, imem.imem_addr_o); end
        ack_now(32'h8);
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (pc_d_o !== 32'h8 || valid_d_o !== 1'b1) begin failures++; $display("FAIL flush_deliver: got %h/%b exp 8/1", pc_d_o, valid_d_o); end
    endtask

    task automatic test_reset_midwait();
        reset_dut();
        ack_now(32'h0); @(negedge clk);
        imem.imem_ack_i = 1'b0; @(negedge clk);
        @(negedge clk);
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h4) begin failures++; $display("FAIL rmw_pending: got %b@%h exp 1@4", imem.imem_req_o, imem.imem_addr_o); end
        rst = 1'b1; ack_now(32'h4);
        #1;
        asserts++; if (imem.imem_req_o !== 1'b0) begin failures++; $display("FAIL rmw_req_in_rst: got %b exp 0", imem.imem_req_o); end
        @(negedge clk);
        asserts++; if (valid_d_o !== 1'b0 || instr_d_o !== NOP || pc_d_o !== 32'h0 || pc_plus4_d_o !== 32'h0) begin failures++; $display("FAIL rmw_outputs: got %b/%h/%h/%h exp 0/%h/0/0", valid_d_o, instr_d_o, pc_d_o, pc_plus4_d_o, NOP); end
        rst = 1'b0; imem.imem_ack_i = 1'b0;
        #1;
        asserts++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h0) begin failures++; $display("FAIL rmw_restart: got %b@%h exp 1@0", imem.imem_req_o, imem.imem_addr_o); end
        ack_now(32'h0);
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (pc_d_o !== 32'h0 || valid_d_o !== 1'b1 || instr_d_o !== KEY) begin failures++; $display("FAIL rmw_deliver: got %h/%b/%h exp 0/1/%h", pc_d_o, valid_d_o, instr_d_o, KEY); end
    endtask

    task automatic test_wrap();
        reset_dut();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect_i = 1'b0;
        asserts++; if (imem.imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h exp fffffffc", imem.imem_addr_o); end
        ack_now(32'hFFFF_FFFC);
        @(negedge clk);
        imem.imem_ack_i = 1'b0;
        asserts++; if (pc_d_o !== 32'hFFFF_FFFC || pc_plus4_d_o !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h/%h exp fffffffc/0", pc_d_o, pc_plus4_d_o); end
        asserts++; if (imem.imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_next: got %h exp 0", imem.imem_addr_o); end
    endtask

    initial begin
        asserts = 0; failures = 0;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        stall_d_i = 1'b0; flush_d_i = 1'b0;
        imem.imem_ack_i = 1'b0; imem.imem_rdata_i = 32'h0;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect();
        test_flush_hold();
        test_reset_midwait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
